// File: rtl/hamming74_serial_tx.sv
// Hamming(7,4) transmitter: encodes an accepted nibble, can flip one codeword bit on request,
// and shifts the codeword out serially over a valid/ready stream.
module hamming74_serial_tx #(
   parameter int unsigned COLS      = 7,
   parameter int unsigned DATA_W    = 4,
   parameter bit          LSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   input  logic              err_inj_en,
   input  logic [2:0]        err_inj_pos,
   output logic              tx_bit,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              tx_sof,
   output logic              tx_eof,
   output logic [COLS-1:0]   codeword,
   output logic              busy
);

   localparam logic [2:0] LastCnt = 3'(COLS - 1);

   typedef enum logic {StIdle, StSend} state_e;

   state_e          state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [COLS-1:0] shift_q, shift_d;
   logic [COLS-1:0] codeword_q, codeword_d;

   logic [COLS-1:0] enc;
   logic            in_send;
   logic            last_beat;
   logic            accept;

   // Bit placement matches the receiver's H rows, so position p maps to codeword bit p-1.
   always_comb begin
      enc    = '0;
      enc[2] = din[0];
      enc[4] = din[1];
      enc[5] = din[2];
      enc[6] = din[3];
      enc[0] = din[0] ^ din[1] ^ din[3];
      enc[1] = din[0] ^ din[2] ^ din[3];
      enc[3] = din[1] ^ din[2] ^ din[3];
      if (err_inj_en) begin
         for (int i = 0; i < COLS; i++) begin
            if (err_inj_pos == 3'(i + 1)) begin
               enc[i] = ~enc[i];
            end
         end
      end
   end

   always_comb begin
      in_send   = (state_q == StSend);
      last_beat = in_send && (cnt_q == LastCnt);
      din_ready = !rst && ((state_q == StIdle) || (last_beat && tx_ready));
      accept    = din_valid && din_ready;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      codeword_d = codeword_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d    = StSend;
               cnt_d      = '0;
               shift_d    = enc;
               codeword_d = enc;
            end
         end
         StSend: begin
            if (tx_ready) begin
               if (!last_beat) begin
                  cnt_d   = cnt_q + 3'd1;
                  shift_d = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
               end else if (accept) begin
                  // Reload on the last beat so consecutive frames run without an idle gap.
                  cnt_d      = '0;
                  shift_d    = enc;
                  codeword_d = enc;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      tx_valid = in_send;
      busy     = in_send;
      tx_bit   = in_send && (LSB_FIRST ? shift_q[0] : shift_q[COLS-1]);
      tx_sof   = in_send && (cnt_q == 3'd0);
      tx_eof   = last_beat;
      codeword = codeword_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         shift_q    <= '0;
         codeword_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         codeword_q <= codeword_d;
      end
   end

endmodule

// File: tb/tb_hamming74_serial_tx.sv
// Bench for hamming74_serial_tx: codeword vector table, serial beat scoreboard, and
// hand-written backpressure / back-to-back / reset / MSB-first sequences.
module tb_hamming74_serial_tx;

   typedef struct {
      logic [3:0] din;
      logic       en;
      logic [2:0] pos;
      logic [6:0] cw;
   } vec_t;

   typedef struct {
      logic b;
      logic sof;
      logic eof;
   } beat_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] din;
   logic       din_valid, din_ready;
   logic       err_inj_en;
   logic [2:0] err_inj_pos;
   logic       tx_bit, tx_valid, tx_ready, tx_sof, tx_eof, busy;
   logic [6:0] codeword;

   logic [3:0] m_din;
   logic       m_din_valid, m_din_ready;
   logic       m_tx_bit, m_tx_valid, m_tx_ready, m_tx_sof, m_tx_eof, m_busy;
   logic [6:0] m_codeword;

   int   checks = 0;
   int   errors = 0;
   vec_t  vecs[$];
   beat_t sb[$];

   always #5 clk = ~clk;

   hamming74_serial_tx #(.COLS(7), .DATA_W(4), .LSB_FIRST(1'b1)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .din_valid   (din_valid),
      .din_ready   (din_ready),
      .err_inj_en  (err_inj_en),
      .err_inj_pos (err_inj_pos),
      .tx_bit      (tx_bit),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_sof      (tx_sof),
      .tx_eof      (tx_eof),
      .codeword    (codeword),
      .busy        (busy)
   );

   hamming74_serial_tx #(.COLS(7), .DATA_W(4), .LSB_FIRST(1'b0)) u_msb (
      .clk         (clk),
      .rst         (rst),
      .din         (m_din),
      .din_valid   (m_din_valid),
      .din_ready   (m_din_ready),
      .err_inj_en  (1'b0),
      .err_inj_pos (3'd0),
      .tx_bit      (m_tx_bit),
      .tx_valid    (m_tx_valid),
      .tx_ready    (m_tx_ready),
      .tx_sof      (m_tx_sof),
      .tx_eof      (m_tx_eof),
      .codeword    (m_codeword),
      .busy        (m_busy)
   );

   function automatic logic [6:0] enc_model(input logic [3:0] d);
      logic [6:0] c;
      c[0] = d[0] ^ d[1] ^ d[3];
      c[1] = d[0] ^ d[2] ^ d[3];
      c[2] = d[0];
      c[3] = d[1] ^ d[2] ^ d[3];
      c[4] = d[1];
      c[5] = d[2];
      c[6] = d[3];
      return c;
   endfunction

   function automatic logic [2:0] syndrome(input logic [6:0] c);
      return {^(c & 7'b1111000), ^(c & 7'b1100110), ^(c & 7'b1010101)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input logic [6:0] cw);
      for (int i = 0; i < 7; i++) begin
         sb.push_back('{b: cw[i], sof: (i == 0), eof: (i == 6)});
      end
   endtask

   // Scoreboard: every serial handshake pops one expected beat.
   always @(negedge clk) begin
      if (!rst && tx_valid && tx_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_beat: got beat bit=%0b with empty queue at %0t", tx_bit, $time);
         end else begin
            beat_t e;
            e = sb.pop_front();
            check("tx_bit", 32'(tx_bit), 32'(e.b));
            check("tx_sof", 32'(tx_sof), 32'(e.sof));
            check("tx_eof", 32'(tx_eof), 32'(e.eof));
         end
      end
   end

   task automatic run_vec(input vec_t v);
      int n;
      n = 0;
      while (!din_ready && n < 20) begin
         tick();
         n++;
      end
      check("din_ready_before_accept", 32'(din_ready), 32'd1);
      din         = v.din;
      err_inj_en  = v.en;
      err_inj_pos = v.pos;
      din_valid   = 1'b1;
      push_frame(v.cw);
      tick();
      din_valid  = 1'b0;
      err_inj_en = 1'b0;
      check("codeword", 32'(codeword), 32'(v.cw));
      check("syndrome", 32'(syndrome(codeword)), 32'(v.en ? v.pos : 3'd0));
      check("first_beat_sof", 32'(tx_sof), 32'd1);
      check("first_beat_valid", 32'(tx_valid), 32'd1);
      repeat (6) tick();
      check("last_beat_eof", 32'(tx_eof), 32'd1);
      tick();
      check("valid_after_frame", 32'(tx_valid), 32'd0);
      check("busy_after_frame", 32'(busy), 32'd0);
      check("queue_drained", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [6:0] cw_bp;
      logic [6:0] b2b_cw [3];
      logic [3:0] nibs [3];
      logic [6:0] col;
      logic [6:0] m_exp;
      logic [3:0] m_nibs [2];
      int idx, gaps, bad_ready, accepts, n;
      bit acc_now;

      rst = 1'b1; din = '0; din_valid = 1'b0; err_inj_en = 1'b0; err_inj_pos = '0;
      tx_ready = 1'b1;
      m_din = '0; m_din_valid = 1'b0; m_tx_ready = 1'b1;

      // Vector table: spec-listed codewords plus the full nibble sweep from the model.
      vecs.push_back('{din: 4'h0, en: 1'b0, pos: 3'd0, cw: 7'b0000000});
      vecs.push_back('{din: 4'hF, en: 1'b0, pos: 3'd0, cw: 7'b1111111});
      vecs.push_back('{din: 4'hB, en: 1'b0, pos: 3'd0, cw: 7'b1010101});
      vecs.push_back('{din: 4'hB, en: 1'b1, pos: 3'd5, cw: 7'b1000101});
      vecs.push_back('{din: 4'hB, en: 1'b1, pos: 3'd0, cw: 7'b1010101});
      vecs.push_back('{din: 4'hB, en: 1'b0, pos: 3'd5, cw: 7'b1010101});
      vecs.push_back('{din: 4'h1, en: 1'b0, pos: 3'd0, cw: 7'b0000111});
      vecs.push_back('{din: 4'h2, en: 1'b0, pos: 3'd0, cw: 7'b0011001});
      vecs.push_back('{din: 4'h3, en: 1'b0, pos: 3'd0, cw: 7'b0011110});
      vecs.push_back('{din: 4'h6, en: 1'b1, pos: 3'd1, cw: 7'b0110010});
      vecs.push_back('{din: 4'h6, en: 1'b1, pos: 3'd7, cw: 7'b1110011});
      for (int d = 0; d < 16; d++) begin
         vecs.push_back('{din: 4'(d), en: 1'b0, pos: 3'd0, cw: enc_model(4'(d))});
      end

      // Reset state
      tick();
      tick();
      check("rst_din_ready", 32'(din_ready), 32'd0);
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_codeword", 32'(codeword), 32'd0);
      check("rst_tx_bit", 32'(tx_bit), 32'd0);
      check("rst_sof_eof", 32'({tx_sof, tx_eof}), 32'd0);
      rst = 1'b0;
      #1;
      check("din_ready_after_rst", 32'(din_ready), 32'd1);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Backpressure at beat 4
      cw_bp = 7'b1001011;
      din = 4'b1000; din_valid = 1'b1;
      push_frame(cw_bp);
      tick();
      din_valid = 1'b0;
      check("bp_codeword", 32'(codeword), 32'(cw_bp));
      repeat (3) tick();
      tx_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("bp_hold_valid", 32'(tx_valid), 32'd1);
         check("bp_hold_bit", 32'(tx_bit), 32'(cw_bp[3]));
         check("bp_hold_sof_eof", 32'({tx_sof, tx_eof}), 32'd0);
         check("bp_din_ready", 32'(din_ready), 32'd0);
      end
      tx_ready = 1'b1;
      repeat (4) tick();
      check("bp_done_valid", 32'(tx_valid), 32'd0);
      check("bp_queue_drained", 32'(sb.size()), 32'd0);

      // Back-to-back frames with din_valid held high
      b2b_cw[0] = 7'b0000111; b2b_cw[1] = 7'b0011001; b2b_cw[2] = 7'b0011110;
      nibs[0] = 4'h1; nibs[1] = 4'h2; nibs[2] = 4'h3;
      idx = 0; gaps = 0; bad_ready = 0; accepts = 0;
      din = nibs[0]; din_valid = 1'b1;
      for (int cyc = 0; cyc < 22; cyc++) begin
         acc_now = 1'b0;
         if (din_ready && tx_valid && !tx_eof) bad_ready++;
         if (din_valid && din_ready) begin
            push_frame(b2b_cw[idx]);
            idx++;
            accepts++;
            acc_now = 1'b1;
         end
         tick();
         if (acc_now) check("b2b_codeword", 32'(codeword), 32'(b2b_cw[idx-1]));
         if (idx == 3) din_valid = 1'b0;
         else din = nibs[idx];
         if (cyc < 21 && !tx_valid) gaps++;
      end
      check("b2b_gaps", 32'(gaps), 32'd0);
      check("b2b_ready_off_eof", 32'(bad_ready), 32'd0);
      check("b2b_accepts", 32'(accepts), 32'd3);
      check("b2b_end_valid", 32'(tx_valid), 32'd0);
      check("b2b_queue_drained", 32'(sb.size()), 32'd0);

      // Reset at beat 3
      din = 4'h6; din_valid = 1'b1;
      push_frame(enc_model(4'h6));
      tick();
      din_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("midrst_tx_valid", 32'(tx_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_codeword", 32'(codeword), 32'd0);
      check("midrst_din_ready", 32'(din_ready), 32'd0);
      sb.delete();
      rst = 1'b0;
      #1;
      run_vec('{din: 4'hB, en: 1'b0, pos: 3'd0, cw: 7'b1010101});

      // MSB-first instance: serial stream reassembled c6 first must equal the codeword
      m_nibs[0] = 4'hB; m_nibs[1] = 4'h1;
      for (int j = 0; j < 2; j++) begin
         m_exp = (j == 0) ? 7'b1010101 : 7'b0000111;
         n = 0;
         while (!m_din_ready && n < 20) begin
            tick();
            n++;
         end
         m_din = m_nibs[j]; m_din_valid = 1'b1;
         tick();
         m_din_valid = 1'b0;
         check("msb_codeword", 32'(m_codeword), 32'(m_exp));
         check("msb_first_bit_c6", 32'(m_tx_bit), 32'(m_exp[6]));
         check("msb_sof", 32'(m_tx_sof), 32'd1);
         col = '0;
         for (int b = 0; b < 7; b++) begin
            col = {col[5:0], m_tx_bit};
            if (b == 6) check("msb_eof", 32'(m_tx_eof), 32'd1);
            tick();
         end
         check("msb_serial_word", 32'(col), 32'(m_exp));
         check("msb_idle_after", 32'(m_tx_valid), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hamming74_serial_tx.md
Name: hamming74_serial_tx

Overview:
- Transmit side of the Hamming(7,4) error-correction demo.
- Accepts a 4-bit data nibble on a valid/ready handshake, encodes it into a 7-bit codeword, and shifts the codeword out one bit per accepted beat on a serial valid/ready stream.
- The codeword bit order matches the receive-side parity check: H rows 7'b1010101, 7'b1100110, 7'b1111000, indexed bit 0 to bit 6.
- An optional single-bit error-injection input exercises the receiver's syndrome and correction path.

Parameters:
- COLS, 7, codeword width. Fixed; not intended to be overridden.
- DATA_W, 4, data nibble width. Fixed.
- LSB_FIRST, 1, serial order: 1 sends codeword bit 0 first, 0 sends bit 6 first.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- din  input  4  data nibble d[3:0]
- din_valid  input  1  din holds a nibble to encode
- din_ready  output  1  block can accept a nibble this cycle
- err_inj_en  input  1  corrupt the nibble being accepted
- err_inj_pos  input  3  Hamming position 1..7 to flip (0 = no flip); sampled with din
- tx_bit  output  1  current serial codeword bit
- tx_valid  output  1  tx_bit is valid
- tx_ready  input  1  downstream accepts tx_bit this cycle
- tx_sof  output  1  high with the first bit of a codeword
- tx_eof  output  1  high with the last bit of a codeword
- codeword  output  7  registered codeword of the frame in flight, including any injected error
- busy  output  1  frame in progress (state SEND)

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - state=IDLE, bit counter=0, shift register=0.
  - codeword=0, tx_valid=0, tx_bit=0, tx_sof=0, tx_eof=0, busy=0.
  - din_ready=0 while rst is high, 1 in the first cycle after.
  - Reset mid-frame abandons the frame with no further tx_valid.
- Encoding, with c[i] = codeword bit i:
  - Data bits: c2=d0, c4=d1, c5=d2, c6=d3.
  - Parity bits: c0=d0^d1^d3, c1=d0^d2^d3, c3=d1^d2^d3.
  - The result has zero syndrome against the H rows above.
- Error injection:
  - If err_inj_en=1 and err_inj_pos=p (1..7) at accept, bit c[p-1] is inverted before the codeword is registered.
  - p=0 or err_inj_en=0 leaves the codeword unchanged.
- States:
  - IDLE:
    - din_ready=1, tx_valid=0.
    - On din_valid&din_ready: register codeword and shift register, set counter=0, go to SEND.
    - Latency: first tx_valid is in the cycle after the accept.
  - SEND:
    - tx_valid=1, busy=1.
    - tx_bit = the current shift-register end (c[cnt] if LSB_FIRST, else c[6-cnt]).
    - tx_sof = (cnt==0); tx_eof = (cnt==6).
    - On tx_valid&tx_ready with cnt<6: cnt+1, shift.
    - With tx_ready=0: hold tx_bit, cnt, sof and eof stable (no drop, no repeat).
- Last beat and back-to-back frames:
  - din_ready = IDLE, or (SEND & cnt==6 & tx_ready).
  - On the last-beat handshake:
    - With din_valid=1: accept the new nibble in the same cycle, load the new codeword, set cnt=0, stay in SEND. Gapless frames result: 7 beats per nibble at full throughput.
    - Otherwise: go to IDLE, tx_valid=0 next cycle.
- din, err_inj_en and err_inj_pos are ignored when din_ready=0.
- codeword output changes only on accept.
- tx_ready held low indefinitely stalls the block; no timeout.

Test Plan:
1. Reset, then din=4'b1011, din_valid=1 for one cycle, tx_ready=1 -> codeword=7'b1010101 one cycle later; tx_bit sequence 1,0,1,0,1,0,1 (bit0 first); tx_sof on beat 1, tx_eof on beat 7; tx_valid low on the 8th cycle after the accept.
2. Sweep all 16 nibbles; model the receiver's syndrome on each collected codeword -> every syndrome equals 3'b000; din=0 gives 7'b0000000 and din=4'hF gives 7'b1111111.
3. din=4'b1011, err_inj_en=1, err_inj_pos=5 -> codeword=7'b1000101; receiver syndrome=3'b101 (=5). err_inj_pos=0 -> 7'b1010101 unchanged.
4. Backpressure: tx_ready=0 for 3 cycles at beat 4 of a frame -> tx_bit, tx_sof and tx_eof held; no beat lost or duplicated; frame completes with the correct 7 bits.
5. Back-to-back: din_valid held high with nibbles 4'h1, 4'h2, 4'h3 and tx_ready=1 -> 21 consecutive tx_valid beats with no gap; din_ready pulses only on the eof beats; codewords 7'b0000111, 7'b0011001, 7'b0011110.
6. rst asserted at beat 3 -> tx_valid, busy and codeword are 0 the next cycle; a new nibble after reset frames correctly starting with tx_sof. LSB_FIRST=0 with din=4'b1011 -> sequence starts with c6=1.
